// File: rtl/shift_add_mult16.sv
// rtl/shift_add_mult16.sv - sequential unsigned shift-and-add multiplier with carry-increment adder

module cia_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NB = WIDTH / 4;

    logic [NB:0] c;

    assign c[0] = cin;

    // Each 4-bit block adds with carry-in 0, then increments by the block carry-in.
    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [4:0] raw;
        assign raw = {1'b0, x[4*g+3:4*g]} + {1'b0, y[4*g+3:4*g]};
        assign sum[4*g+3:4*g] = raw[3:0] + {3'b000, c[g]};
        assign c[g+1] = raw[4] | (c[g] & (&raw[3:0]));
    end

    assign cout = c[NB];
endmodule

module shift_add_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH) + 1;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("shift_add_mult16: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [WIDTH-1:0]     m;
    logic [2*WIDTH-1:0]   p;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   result;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [2*WIDTH-1:0]   p_next;
    logic                 last_iter;

    assign addend = p[0] ? m : '0;

    cia_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (p[2*WIDTH-1:WIDTH]),
        .y    (addend),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry-out lands in the accumulator MSB so full-scale products are kept.
    assign p_next    = {add_cout, add_sum, p[WIDTH-1:1]};
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m      <= '0;
            p      <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        p   <= {{WIDTH{1'b0}}, b};
                        cnt <= '0;
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        result <= p_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = result;
endmodule

// File: tb/tb_shift_add_mult16.sv
// tb/tb_shift_add_mult16.sv - self-checking bench for shift_add_mult16

module tb_shift_add_mult16;
    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    shift_add_mult16 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint unsigned r;
        r = longint'(x) * longint'(y);
        return r[2*W-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one multiply from a single-cycle start pulse; edge k is k clocks after acceptance.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic [2*W-1:0] prod, output int lat,
                         output int busy_cycles, output int done_cycles);
        @(negedge clk);
        a = xa; b = xb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1; busy_cycles = 0; done_cycles = 0; prod = '0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_cycles++;
                if (lat < 0) begin
                    lat = k;
                    prod = product;
                end
            end
        end
    endtask

    task automatic run_checked(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                               input logic [2*W-1:0] exp);
        logic [2*W-1:0] pr;
        int lat, bc, dc;
        do_op(xa, xb, pr, lat, bc, dc);
        check({tag, " product"}, pr, exp);
        check({tag, " latency"}, lat, W);
        check({tag, " busy_cycles"}, bc, W);
        check({tag, " done_cycles"}, dc, 1);
    endtask

    initial begin
        logic [2*W-1:0] pr;
        int lat, bc, dc, k, ndone, seen;
        int done_t[3];
        logic [2*W-1:0] done_p[3];
        logic [W-1:0] ra, rb;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{a: 16'd3,    b: 16'd5,    exp: 32'h0000000F};
        vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, exp: 32'hFFFE0001};
        vecs[2] = '{a: 16'h1234, b: 16'h0000, exp: 32'h00000000};
        vecs[3] = '{a: 16'h0000, b: 16'hABCD, exp: 32'h00000000};
        vecs[4] = '{a: 16'h8000, b: 16'h8000, exp: 32'h40000000};
        vecs[5] = '{a: 16'h00FF, b: 16'h0100, exp: 32'h0000FF00};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, pr, lat, bc, dc);
            check($sformatf("rand%0d product", i), pr, ref_mul(ra, rb));
            check($sformatf("rand%0d latency", i), lat, W);
        end

        // start pulsed and operands changed mid-RUN must not disturb 7*9
        @(negedge clk);
        a = 16'd7; b = 16'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a = 16'd2; b = 16'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = 16'h5555; b = 16'h3333;
        k = 5; lat = -1; pr = '0;
        while (k < 40 && lat < 0) begin
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                lat = k;
                pr = product;
            end
        end
        check("ignore product", pr, 63);
        check("ignore latency", lat, W);
        ndone = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("ignore no extra done", ndone, 0);
        check("ignore product held", product, 63);

        // asynchronous reset in the middle of 0x00FF*0x0100
        @(negedge clk);
        a = 16'h00FF; b = 16'h0100; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_checked("after_reset", 16'd4, 16'd4, 32'd16);

        // start held high: back-to-back operations
        @(negedge clk);
        a = 16'd1; b = 16'd1; start = 1'b1;
        seen = 0;
        for (int c = 0; c < 120 && seen < 3; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_t[seen] = c;
                done_p[seen] = product;
                seen++;
                if (seen == 1) begin a = 16'h8000; b = 16'd2; end
                if (seen == 2) begin a = 16'hFFFF; b = 16'd1; end
                if (seen == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b done count", seen, 3);
        if (seen == 3) begin
            check("b2b product0", done_p[0], 32'h00000001);
            check("b2b product1", done_p[1], 32'h00010000);
            check("b2b product2", done_p[2], 32'h0000FFFF);
            check("b2b spacing01", done_t[1] - done_t[0], W + 2);
            check("b2b spacing12", done_t[2] - done_t[1], W + 2);
        end
        repeat (25) @(posedge clk);
        #1;
        check("b2b idle after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
